// File: rtl/debug_pkg.sv
// Shared definitions for the debug controller: FSM states, halt cause codes
// and the production debounce length.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'b00,
        CAUSE_DEBUG = 2'b01,
        CAUSE_BP    = 2'b10,
        CAUSE_KEY   = 2'b11
    } cause_t;

    // Key must be stable this many core cycles before a level change counts.
    localparam logic [19:0] DEBOUNCE_DEFAULT = 20'd500000;

    // Cause priority when several halt sources fire together:
    // debug trap first, then breakpoint, then key/host request.
    function automatic cause_t select_cause(input logic dbg, input logic bp);
        if (dbg) begin
            return CAUSE_DEBUG;
        end
        if (bp) begin
            return CAUSE_BP;
        end
        return CAUSE_KEY;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a
// rising-edge detector producing one press pulse per debounced 0->1 change.
module key_debounce
    import debug_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d;
    logic        prev_q;
    logic [19:0] cnt_q, cnt_d;

    // Bring the raw asynchronous key into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so bounces never reach the limit.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    // Accepted level, counter and the delayed copy used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_q;
        end
    end

    assign level = level_q;
    assign press = level_q & ~prev_q;

endmodule

// File: rtl/debug_ctrl.sv
// Core debug controller: halts the pipeline on debug traps, PC breakpoints,
// host requests or the continue key, and resumes or single-steps on a press.
module debug_ctrl
    import debug_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int          NUM_BP          = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        continue_key,
    input  logic        step_mode,
    input  logic        is_debug,
    input  logic        halt_req,
    input  logic [63:0] pc,
    input  logic        bp_we,
    input  logic [1:0]  bp_sel,
    input  logic [63:0] bp_addr,
    input  logic        bp_valid,
    output logic        stall,
    output logic        halted,
    output logic [1:0]  halt_cause,
    output logic [31:0] retired
);

    state_t        state_q, state_d;
    cause_t        cause_q, cause_d;
    logic          mask_q, mask_d;
    logic [31:0]   retired_q, retired_d;
    logic [NUM_BP-1:0] bp_match;
    logic          bp_hit;
    logic          deb_level, deb_press;
    logic          key_press;
    logic          trigger;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
        .clk  (clk),
        .rst  (rst),
        .key  (continue_key),
        .level(deb_level),
        .press(deb_press)
    );

    // A press only ever coincides with a high debounced level.
    assign key_press = deb_press & deb_level;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BP; gi++) begin : g_bp
            logic [63:0] addr_q;
            logic        valid_q;

            // Breakpoint register; a write lands at the edge, so the compare
            // in the write cycle still sees the previous contents.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    addr_q  <= '0;
                    valid_q <= 1'b0;
                end else if (bp_we && (bp_sel == 2'(gi))) begin
                    addr_q  <= bp_addr;
                    valid_q <= bp_valid;
                end
            end

            assign bp_match[gi] = valid_q && (pc == addr_q);
        end
    endgenerate

    assign bp_hit  = |bp_match;
    assign trigger = (is_debug | bp_hit | halt_req | key_press) & ~mask_q;

    // Next state, stall and halt cause; stall reacts to a trigger in the same
    // cycle so the offending instruction never retires.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        mask_d  = 1'b0;
        stall   = 1'b0;
        halted  = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall = trigger;
                if (trigger) begin
                    state_d = ST_HALT;
                    cause_d = select_cause(is_debug, bp_hit);
                end
            end
            ST_HALT: begin
                stall  = 1'b1;
                halted = 1'b1;
                if (key_press) begin
                    state_d = step_mode ? ST_STEP : ST_RUN;
                    cause_d = CAUSE_NONE;
                    mask_d  = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                cause_d = CAUSE_KEY;
            end
            default: begin
                state_d = ST_RUN;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    assign retired_d = stall ? retired_q : retired_q + 32'd1;

    // State, cause, one-cycle resume mask and the retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            cause_q   <= CAUSE_NONE;
            mask_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            mask_q    <= mask_d;
            retired_q <= retired_d;
        end
    end

    assign halt_cause = cause_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl: directed scenarios with a spec-level model checked on
// every cycle, plus hand-computed literal checkpoints.
module tb_debug_ctrl;

    localparam int D   = 16;
    localparam int NBP = 2;

    logic        clk = 1'b0;
    logic        rst, continue_key, step_mode, is_debug, halt_req;
    logic [63:0] pc;
    logic        bp_we;
    logic [1:0]  bp_sel;
    logic [63:0] bp_addr;
    logic        bp_valid;
    logic        stall, halted;
    logic [1:0]  halt_cause;
    logic [31:0] retired;

    always #5 clk = ~clk;

    debug_ctrl #(
        .DEBOUNCE_CYCLES(20'd16),
        .NUM_BP         (NBP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .continue_key(continue_key),
        .step_mode   (step_mode),
        .is_debug    (is_debug),
        .halt_req    (halt_req),
        .pc          (pc),
        .bp_we       (bp_we),
        .bp_sel      (bp_sel),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .stall       (stall),
        .halted      (halted),
        .halt_cause  (halt_cause),
        .retired     (retired)
    );

    // ---------------- behavioural model ----------------
    // m_state: 0 = running, 1 = halted, 2 = single step
    int          m_state;
    bit          m_mask;
    logic [1:0]  m_cause;
    logic [31:0] m_ret;
    logic [63:0] m_bpa [NBP];
    bit          m_bpv [NBP];
    bit          m_lvl, m_press;
    bit          hist[$];
    int          pre_seq  = 0;
    int          pre_seen = 0;
    bit          md_st, md_hit, md_trig, md_nmask, md_diff;

    int n_tests = 0;
    int n_fail  = 0;
    bit cpu_mode = 1'b0;

    function automatic bit m_hit();
        for (int i = 0; i < NBP; i++) begin
            if (m_bpv[i] && pc == m_bpa[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        bit t;
        t = is_debug || m_hit() || halt_req || m_press;
        if (m_state == 1) return 1'b1;
        if (m_state == 2) return 1'b0;
        return t && !m_mask;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0;
            m_mask  = 1'b0;
            m_cause = 2'd0;
            m_ret   = 32'd0;
            for (int i = 0; i < NBP; i++) begin
                m_bpa[i] = 64'd0;
                m_bpv[i] = 1'b0;
            end
            m_lvl   = 1'b0;
            m_press = 1'b0;
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back(1'b0);
        end else begin
            md_st    = m_stall();
            md_hit   = m_hit();
            md_trig  = (is_debug || md_hit || halt_req || m_press) && !m_mask;
            md_nmask = 1'b0;
            if (m_state == 0) begin
                if (md_trig) begin
                    m_state = 1;
                    m_cause = is_debug ? 2'd1 : (md_hit ? 2'd2 : 2'd3);
                end
            end else if (m_state == 1) begin
                if (m_press) begin
                    m_state  = step_mode ? 2 : 0;
                    m_cause  = 2'd0;
                    md_nmask = 1'b1;
                end
            end else begin
                m_state = 1;
                m_cause = 2'd3;
            end
            m_mask = md_nmask;
            if (pre_seq != pre_seen) begin
                pre_seen = pre_seq;
                m_ret    = 32'hFFFF_FFFE;
            end
            if (!md_st) m_ret = m_ret + 32'd1;
            if (bp_we && int'(bp_sel) < NBP) begin
                m_bpa[bp_sel] = bp_addr;
                m_bpv[bp_sel] = bp_valid;
            end
            // key: the level flips once the D samples that have cleared the
            // two synchronizer stages all disagree with it
            hist.push_back(continue_key);
            void'(hist.pop_front());
            md_diff = 1'b1;
            for (int i = 0; i < D; i++) begin
                if (hist[i] == m_lvl) md_diff = 1'b0;
            end
            m_press = 1'b0;
            if (md_diff) begin
                m_lvl   = ~m_lvl;
                m_press = m_lvl;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: compare every output with the model, then advance. In
    // cpu_mode the PC moves on whenever the instruction retired.
    task automatic tick();
        bit s;
        @(negedge clk);
        s = m_stall();
        check("stall", {63'd0, stall}, {63'd0, s});
        check("halted", {63'd0, halted}, {63'd0, (m_state == 1)});
        check("halt_cause", {62'd0, halt_cause}, {62'd0, m_cause});
        if (pre_seq == pre_seen) check("retired", {32'd0, retired}, {32'd0, m_ret});
        @(posedge clk);
        #1;
        if (cpu_mode && !s) pc = pc + 64'd4;
    endtask

    task automatic press_key();
        continue_key = 1'b1;
        repeat (22) tick();
        continue_key = 1'b0;
        repeat (22) tick();
    endtask

    logic [31:0] r0;

    initial begin
        rst = 1'b1; continue_key = 1'b0; step_mode = 1'b0; is_debug = 1'b0;
        halt_req = 1'b0; pc = 64'd0; bp_we = 1'b0; bp_sel = 2'd0;
        bp_addr = 64'd0; bp_valid = 1'b0;
        #1;
        repeat (3) tick();
        check("rst_halted", {63'd0, halted}, 64'd0);
        check("rst_cause", {62'd0, halt_cause}, 64'd0);
        check("rst_retired", {32'd0, retired}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        rst = 1'b0;
        repeat (4) tick();
        check("run_retired4", {32'd0, retired}, 64'd4);

        // debug trap at 0x40
        r0 = retired;
        pc = 64'h40; is_debug = 1'b1;
        #1 check("dbg_stall", {63'd0, stall}, 64'd1);
        tick();
        is_debug = 1'b0; pc = 64'h44;
        #1;
        check("dbg_halted", {63'd0, halted}, 64'd1);
        check("dbg_cause", {62'd0, halt_cause}, 64'd1);
        check("dbg_ret", {32'd0, retired}, {32'd0, r0});
        repeat (3) tick();
        check("dbg_frozen", {32'd0, retired}, {32'd0, r0});
        step_mode = 1'b0;
        press_key();
        check("dbg_resume", {63'd0, halted}, 64'd0);

        // out-of-range breakpoint slot is ignored
        bp_we = 1'b1; bp_sel = 2'd3; bp_addr = 64'h90; bp_valid = 1'b1;
        tick();
        bp_we = 1'b0; pc = 64'h90;
        #1 check("bp_sel3", {63'd0, stall}, 64'd0);
        tick();
        // same-cycle write uses the old (invalid) breakpoint
        bp_we = 1'b1; bp_sel = 2'd0; bp_addr = 64'h80; bp_valid = 1'b1; pc = 64'h80;
        #1 check("bp_old", {63'd0, stall}, 64'd0);
        tick();
        bp_we = 1'b0;
        #1 check("bp_new", {63'd0, stall}, 64'd1);
        tick();
        check("bp_halted", {63'd0, halted}, 64'd1);
        check("bp_cause", {62'd0, halt_cause}, 64'd2);
        cpu_mode = 1'b1;
        r0 = retired;
        press_key();
        check("bp_noreh", {63'd0, halted}, 64'd0);
        check("bp_resret", {32'd0, retired}, {32'd0, r0 + 32'd25});

        // host halt then three single steps
        halt_req = 1'b1;
        #1 check("hr_stall", {63'd0, stall}, 64'd1);
        tick();
        halt_req = 1'b0;
        #1 check("hr_cause", {62'd0, halt_cause}, 64'd3);
        r0 = retired;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("hr_ignored", {63'd0, halted}, 64'd1);
        step_mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            press_key();
            check("step_halted", {63'd0, halted}, 64'd1);
            check("step_cause", {62'd0, halt_cause}, 64'd3);
        end
        check("step_ret3", {32'd0, retired}, {32'd0, r0 + 32'd3});

        // key bounce then a real hold
        step_mode = 1'b0;
        press_key();
        cpu_mode = 1'b0; pc = 64'h200;
        for (int k = 0; k < 3; k++) begin
            continue_key = 1'b1;
            repeat (10) tick();
            continue_key = 1'b0;
            repeat (10) tick();
        end
        repeat (10) tick();
        check("bounce_none", {63'd0, halted}, 64'd0);
        continue_key = 1'b1;
        repeat (40) tick();
        check("hold_halt", {63'd0, halted}, 64'd1);
        check("hold_cause", {62'd0, halt_cause}, 64'd3);
        continue_key = 1'b0;
        repeat (22) tick();
        check("hold_once", {63'd0, halted}, 64'd1);

        // press and debug trap in the same cycle
        press_key();
        continue_key = 1'b1;
        repeat (18) tick();
        is_debug = 1'b1;
        #1 check("same_stall", {63'd0, stall}, 64'd1);
        tick();
        is_debug = 1'b0;
        #1;
        check("same_halted", {63'd0, halted}, 64'd1);
        check("same_cause", {62'd0, halt_cause}, 64'd1);
        repeat (4) tick();
        continue_key = 1'b0;
        repeat (22) tick();
        check("same_single", {63'd0, halted}, 64'd1);

        // retired wrap
        press_key();
        cpu_mode = 1'b1; pc = 64'h300;
        tick();
        force dut.retired_q = 32'hFFFF_FFFE;
        pre_seq = pre_seq + 1;
        #1 release dut.retired_q;
        tick();
        check("wrap_ff", {32'd0, retired}, 64'hFFFF_FFFF);
        tick();
        check("wrap_zero", {32'd0, retired}, 64'd0);

        // reset in the middle of a single step
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        step_mode = 1'b1;
        continue_key = 1'b1;
        repeat (19) tick();
        check("g_in_step", {63'd0, halted}, 64'd0);
        rst = 1'b1;
        #1;
        check("g_halted", {63'd0, halted}, 64'd0);
        check("g_cause", {62'd0, halt_cause}, 64'd0);
        check("g_retired", {32'd0, retired}, 64'd0);
        continue_key = 1'b0;
        repeat (2) tick();
        rst = 1'b0; cpu_mode = 1'b0; pc = 64'h80;
        #1 check("g_bp_clear", {63'd0, stall}, 64'd0);
        repeat (25) tick();
        check("g_no_press", {63'd0, halted}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
